// File: rtl/mips_multi_pkg.sv
// mips_multi_pkg: state encoding, opcode/funct values and control select codes for mips_multi_ctrl
package mips_multi_pkg;
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    IMMEX   = 4'd8,
    IMMWB   = 4'd9,
    BEQEX   = 4'd10,
    BNEEX   = 4'd11,
    JEX     = 4'd12,
    JALEX   = 4'd13,
    ILLEGAL = 4'd14
  } state_t;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [1:0] AOP_ADD = 2'd0;
  localparam logic [1:0] AOP_SUB = 2'd1;
  localparam logic [1:0] AOP_FN  = 2'd2;
  localparam logic [1:0] AOP_IMM = 2'd3;
  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;
  localparam logic [1:0] SRCB_B   = 2'd0;
  localparam logic [1:0] SRCB_4   = 2'd1;
  localparam logic [1:0] SRCB_IMM = 2'd2;
  localparam logic [1:0] SRCB_BR  = 2'd3;
  localparam logic [1:0] PC_ALU  = 2'd0;
  localparam logic [1:0] PC_OUT  = 2'd1;
  localparam logic [1:0] PC_JUMP = 2'd2;
  localparam logic [1:0] PC_EXC  = 2'd3;
endpackage

// File: rtl/mips_alu_dec.sv
// mips_alu_dec: maps aluop/op/funct to alucontrol and flags which R-type functs are implemented
module mips_alu_dec
  import mips_multi_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       funct_ok
);
  logic [2:0] fn_ctl, imm_ctl;
  always_comb begin
    fn_ctl = funct == FN_SUB ? ALU_SUB : funct == FN_AND ? ALU_AND :
             funct == FN_OR ? ALU_OR : funct == FN_SLT ? ALU_SLT : ALU_ADD;
    imm_ctl = op == OP_ANDI ? ALU_AND : op == OP_ORI ? ALU_OR : op == OP_SLTI ? ALU_SLT : ALU_ADD;
    funct_ok = funct == FN_ADD || funct == FN_SUB || funct == FN_AND || funct == FN_OR || funct == FN_SLT;
    alucontrol = aluop == AOP_SUB ? ALU_SUB : aluop == AOP_FN ? fn_ctl : aluop == AOP_IMM ? imm_ctl : ALU_ADD;
  end
endmodule

// File: rtl/mips_multi_ctrl.sv
// mips_multi_ctrl: multicycle MIPS control FSM with memory handshake and retire counter; define MIPS_EXC_EN to trap illegal instructions
module mips_multi_ctrl
  import mips_multi_pkg::*;
#(
  parameter int          CNT_W      = 32,
  parameter bit          SYNC_MEM   = 1'b0,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             memreq,
  output logic             memwrite,
  output logic             pcen,
  output logic             irwrite,
  output logic             regwrite,
  output logic             alusrca,
  output logic             iord,
  output logic             extsel,
  output logic [1:0]       regdst,
  output logic [1:0]       memtoreg,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [2:0]       alucontrol,
  output logic             retired,
  output logic [CNT_W-1:0] instr_count,
  output logic             exc
);
  state_t state, next;
  logic [1:0] aluop;
  logic ready, funct_ok;
  assign ready = mem_ready | SYNC_MEM;
  // The vector itself is muxed in by the datapath; only its alignment matters here.
  if (EXC_VECTOR[1:0] != 2'b00) begin : g_vec_check
    $error("EXC_VECTOR must be word aligned");
  end
  mips_alu_dec u_alu_dec (
    .aluop(aluop),
    .op(op),
    .funct(funct),
    .alucontrol(alucontrol),
    .funct_ok(funct_ok)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      instr_count <= '0;
    end else begin
      state <= next;
      if (retired) instr_count <= instr_count + CNT_W'(1);
    end
  end
  always_comb begin
    next = state;
    memreq = 1'b0;
    memwrite = 1'b0;
    pcen = 1'b0;
    irwrite = 1'b0;
    regwrite = 1'b0;
    alusrca = 1'b0;
    iord = 1'b0;
    extsel = 1'b0;
    regdst = DST_RT;
    memtoreg = WB_ALU;
    alusrcb = SRCB_B;
    pcsrc = PC_ALU;
    aluop = AOP_ADD;
    retired = 1'b0;
    exc = 1'b0;
    case (state)
      FETCH: begin
        memreq = 1'b1;
        alusrcb = SRCB_4;
        irwrite = ready;
        pcen = ready;
        next = ready ? DECODE : FETCH;
      end
      DECODE: begin
        alusrcb = SRCB_BR;
        next = (op == OP_LW || op == OP_SW) ? MEMADR :
               op == OP_RTYPE ? (funct_ok ? RTYPEEX : ILLEGAL) :
               op == OP_BEQ ? BEQEX : op == OP_BNE ? BNEEX :
               (op == OP_ADDI || op == OP_ANDI || op == OP_ORI || op == OP_SLTI) ? IMMEX :
               op == OP_J ? JEX : op == OP_JAL ? JALEX : ILLEGAL;
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        next = op == OP_LW ? MEMRD : MEMWR;
      end
      MEMRD: begin
        memreq = 1'b1;
        iord = 1'b1;
        next = ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = WB_MEM;
        retired = 1'b1;
        next = FETCH;
      end
      MEMWR: begin
        memreq = 1'b1;
        memwrite = 1'b1;
        iord = 1'b1;
        retired = ready;
        next = ready ? FETCH : MEMWR;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop = AOP_FN;
        next = RTYPEWB;
      end
      RTYPEWB: begin
        regdst = DST_RD;
        regwrite = 1'b1;
        retired = 1'b1;
        next = FETCH;
      end
      IMMEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        extsel = op == OP_ANDI || op == OP_ORI;
        aluop = AOP_IMM;
        next = IMMWB;
      end
      IMMWB: begin
        regwrite = 1'b1;
        retired = 1'b1;
        next = FETCH;
      end
      BEQEX, BNEEX: begin
        alusrca = 1'b1;
        aluop = AOP_SUB;
        pcsrc = PC_OUT;
        pcen = state == BEQEX ? zero : !zero;
        retired = 1'b1;
        next = FETCH;
      end
      JEX: begin
        pcsrc = PC_JUMP;
        pcen = 1'b1;
        retired = 1'b1;
        next = FETCH;
      end
      JALEX: begin
        // PC already holds PC+4 here, which is the link value written to $31.
        pcsrc = PC_JUMP;
        pcen = 1'b1;
        regwrite = 1'b1;
        regdst = DST_RA;
        memtoreg = WB_PC;
        retired = 1'b1;
        next = FETCH;
      end
      default: begin
`ifdef MIPS_EXC_EN
        pcsrc = PC_EXC;
        pcen = 1'b1;
        exc = 1'b1;
`else
        retired = 1'b1;
`endif
        next = FETCH;
      end
    endcase
  end
endmodule
